// File: rtl/piano_pkg.sv
// piano_pkg: shared note frequencies, table size limit and FSM state encoding
package piano_pkg;
  localparam int MAX_NOTES = 16;
  localparam int unsigned FREQ_HZ [MAX_NOTES] = '{
    261, 293, 329, 349, 392, 440, 493, 523,
    587, 659, 698, 784, 880, 987, 1046, 1174
  };
  typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_REL} state_e;
endpackage

// File: rtl/tone_table.sv
// tone_table: combinational half-period ROM with octave shift and minimum-of-one clamp
module tone_table
  import piano_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic [3:0]  note_i,
  input  logic [1:0]  oct_i,
  output logic [31:0] half_o
);
  logic [31:0] rom [MAX_NOTES];
  logic [31:0] shifted;
  for (genvar i = 0; i < MAX_NOTES; i++) begin : g_rom
    assign rom[i] = 32'(CLK_HZ / FREQ_HZ[i] / 2);
  end
  always_comb begin
    shifted = rom[note_i] >> oct_i;
    half_o  = (shifted == '0) ? 32'd1 : shifted;
  end
endmodule

// File: rtl/tone_gen.sv
// tone_gen: square-wave note generator with a release tail after key-up
module tone_gen
  import piano_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned NUM_NOTES   = 16,
  parameter int          KEY_W       = 5,
  parameter int unsigned RELEASE_CYC = 10_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_on,
  input  logic [KEY_W-1:0] key,
  input  logic [1:0]       octave,
  output logic             buzzer,
  output logic             active,
  output logic [KEY_W-1:0] note_q
);
  state_e      state_q;
  logic [1:0]  oct_q;
  logic [31:0] cnt_q, rel_q, half, cnt_d;
  logic        buz_q, act_q, buz_d, valid, same, wrap;
  tone_table #(.CLK_HZ(CLK_HZ)) u_table (
    .note_i(4'(note_q)),
    .oct_i (oct_q),
    .half_o(half)
  );
  always_comb begin
    valid = key_on && (32'(key) < NUM_NOTES);
    same  = {key, octave} == {note_q, oct_q};
    wrap  = cnt_q == half - 32'd1;
    cnt_d = wrap ? '0 : cnt_q + 32'd1;
    buz_d = wrap ? ~buz_q : buz_q;
  end
  // A changed note or octave always restarts phase from zero, from any state
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ST_IDLE;
      note_q  <= '0;
      oct_q   <= '0;
      cnt_q   <= '0;
      rel_q   <= '0;
      buz_q   <= 1'b0;
      act_q   <= 1'b0;
    end else if (valid && (state_q == ST_IDLE || !same)) begin
      state_q <= ST_PLAY;
      note_q  <= key;
      oct_q   <= octave;
      cnt_q   <= '0;
      buz_q   <= 1'b0;
      act_q   <= 1'b1;
    end else if (valid) begin
      state_q <= ST_PLAY;
      cnt_q   <= cnt_d;
      buz_q   <= buz_d;
    end else if (state_q == ST_PLAY && RELEASE_CYC != 0) begin
      state_q <= ST_REL;
      rel_q   <= RELEASE_CYC - 32'd1;
      cnt_q   <= cnt_d;
      buz_q   <= buz_d;
    end else if (state_q == ST_REL && rel_q != '0) begin
      rel_q   <= rel_q - 32'd1;
      cnt_q   <= cnt_d;
      buz_q   <= buz_d;
    end else begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      buz_q   <= 1'b0;
      act_q   <= 1'b0;
    end
  assign buzzer = buz_q;
  assign active = act_q;
endmodule

// File: tb/tb_tone_gen.sv
// tb_tone_gen: randomized scoreboard bench for tone_gen against an arithmetic phase model
module tb_tone_gen;
  localparam int unsigned CLK = 1_000_000;
  localparam int unsigned NUM = 12;
  localparam int unsigned RC  = 300;
  localparam int unsigned FREQ [16] = '{261, 293, 329, 349, 392, 440, 493, 523,
                                        587, 659, 698, 784, 880, 987, 1046, 1174};
  typedef struct { bit buz; bit act; logic [4:0] note; } exp_t;

  logic clk = 0, rst = 1, key_on = 0, buzzer, active;
  logic [4:0] key = '0, note_q;
  logic [1:0] octave = '0;
  int checks = 0, errors = 0, prints = 0;
  exp_t q[$];

  bit snd = 0, in_rel = 0;
  logic [4:0] m_note = '0;
  logic [1:0] m_oct = '0;
  longint n_edge = 0, t0 = 0, dl = 0;

  tone_gen #(.CLK_HZ(CLK), .NUM_NOTES(NUM), .KEY_W(5), .RELEASE_CYC(RC)) dut (
    .clk(clk), .rst(rst), .key_on(key_on), .key(key), .octave(octave),
    .buzzer(buzzer), .active(active), .note_q(note_q)
  );

  always #5 clk = ~clk;

  function automatic longint half_of(input logic [4:0] n, input logic [1:0] o);
    longint h = longint'((CLK / FREQ[n[3:0]] / 2) >> o);
    return (h == 0) ? 1 : h;
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      if (prints < 30) $display("FAIL %s at edge %0d: got %0d expected %0d", name, n_edge, act, req);
      prints++;
    end
  endtask

  // Buzzer level follows from elapsed edges since the last phase start
  task automatic model_edge();
    bit v = key_on && (key < NUM);
    exp_t e;
    n_edge++;
    if (!snd) begin
      if (v) begin snd = 1; in_rel = 0; m_note = key; m_oct = octave; t0 = n_edge; end
    end else if (v) begin
      if (key != m_note || octave != m_oct) begin m_note = key; m_oct = octave; t0 = n_edge; end
      in_rel = 0;
    end else if (!in_rel) begin
      if (RC == 0) snd = 0;
      else begin in_rel = 1; dl = n_edge + RC; end
    end else if (n_edge == dl) snd = 0;
    e.buz = snd && (((n_edge - t0) / half_of(m_note, m_oct)) % 2 == 1);
    e.act = snd;
    e.note = m_note;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run(input int n, input bit on, input int kk, input int oo);
    key_on = on; key = 5'(kk); octave = 2'(oo);
    repeat (n) tick();
  endtask

  task automatic model_reset();
    snd = 0; in_rel = 0; m_note = '0; m_oct = '0;
  endtask

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("buzzer", buzzer, e.buz);
      chk("active", active, e.act);
      chk("note_q", note_q, e.note);
    end
  end

  initial begin
    #1;
    chk("rst_buzzer", buzzer, 0);
    chk("rst_active", active, 0);
    chk("rst_note", note_q, 0);
    repeat (3) @(posedge clk);
    #1 rst = 0;
    run(5000, 1, 5, 0);
    run(1500, 1, 5, 1);
    run(1500, 1, 5, 0);
    run(1000, 1, 0, 0);
    run(RC + 200, 0, 0, 0);
    run(1000, 1, 0, 0);
    run(RC / 2, 0, 0, 0);
    run(1000, 1, 0, 0);
    run(RC - 1, 0, 3, 0);
    run(500, 1, 0, 0);
    run(RC + 50, 0, 0, 0);
    run(200, 1, 20, 0);
    run(50, 1, 12, 0);
    run(600, 1, 3, 2);
    run(RC + 100, 1, 20, 2);
    run(300, 1, 11, 1);
    run(50, 1, 13, 1);
    for (int s = 0; s < 150; s++) begin
      int k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, NUM - 1));
      run(int'($urandom_range(1, 300)), $urandom_range(0, 4) != 0, k, int'($urandom_range(0, 3)));
    end
    key_on = 1; key = 5'd11; octave = 2'd3;
    for (int i = 0; i < 500 && !(q.size() != 0 && q[$].buz); i++) tick();
    @(negedge clk);
    #1 rst = 1;
    #1;
    chk("async_buzzer", buzzer, 0);
    chk("async_active", active, 0);
    chk("async_note", note_q, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    run(1000, 1, 2, 0);
    run(RC + 100, 0, 2, 0);
    repeat (2) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tone_gen.md
TONE_GEN -- requirements
Module: tone_gen

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 100_000_000, meaning the input clock frequency in Hz.
REQ-002 The block SHALL have parameter NUM_NOTES, default 16, meaning the number of table notes; legal range is 1..16.
REQ-003 The block SHALL have parameter KEY_W, default 5, meaning the key index width.
REQ-004 The block SHALL have parameter RELEASE_CYC, default 10_000_000, meaning the tail length in clocks after key release (100 ms at default).
REQ-005 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port key_on, input, 1 bit: a note is requested while high.
REQ-008 Port key, input, KEY_W bits: note index, where 0 is C4 and 15 is D6.
REQ-009 Port octave, input, 2 bits: upward octave shift, 0..3.
REQ-010 Port buzzer, output, 1 bit: square-wave tone output, registered.
REQ-011 Port active, output, 1 bit: high when state is not IDLE, registered.
REQ-012 Port note_q, output, KEY_W bits: latched note index currently sounding, registered.

Function
REQ-013 The half-period table SHALL be HALF[i] = CLK_HZ / f_i / 2, evaluated with integer division left to right.
REQ-014 The table frequencies f_0..f_15 SHALL be 261, 293, 329, 349, 392, 440, 493, 523, 587, 659, 698, 784, 880, 987, 1046, 1174 Hz.
REQ-015 The effective half period SHALL be HALF[note_q] >> oct_q, clamped to a minimum of 1.
REQ-016 The counter SHALL be 32 bits wide and SHALL count 0..half-1.
REQ-017 When the counter equals half-1, the counter SHALL go to 0 and buzzer SHALL toggle; the output period is therefore 2*half clocks.
REQ-018 A key is valid only when key_on=1 and key < NUM_NOTES; an invalid key SHALL be treated exactly as key_on=0.
REQ-019 The state machine SHALL have three states: IDLE, PLAY, RELEASE.
REQ-020 IDLE: buzzer=0 and counter=0. A valid key SHALL move to PLAY, latch key into note_q and octave into oct_q, and start the counter at 0.
REQ-021 PLAY with a valid key whose {key, octave} equals the latched value: tone continues with no phase disturbance.
REQ-022 PLAY with a valid key whose {key, octave} differs: relatch, set counter=0 and buzzer=0 in the same cycle (phase restart), and stay in PLAY.
REQ-023 PLAY with no valid key: go to RELEASE, load the release counter with RELEASE_CYC-1, and keep toggling the latched note.
REQ-024 PLAY with no valid key and RELEASE_CYC=0: go directly to IDLE, with buzzer=0 and counter=0 on the next cycle.
REQ-025 RELEASE: the release counter SHALL decrement each cycle. When it is 0 with no valid key, go to IDLE with buzzer=0 and counter=0.
REQ-026 RELEASE with a valid key equal to the latched value: return to PLAY without phase restart.
REQ-027 RELEASE with a valid key that differs: return to PLAY and apply the REQ-022 relatch.
REQ-028 If a valid key arrives on the same cycle the release counter reaches 0, the key SHALL win and the state goes to PLAY.
REQ-029 A change on octave alone SHALL count as a note change.
REQ-030 Inputs SHALL be sampled directly and are assumed synchronous to clk; debouncing is outside this block.

Reset
REQ-031 While rst=1, state SHALL be IDLE and buzzer, active, note_q, oct_q, counter and the release counter SHALL all be 0.
REQ-032 Reset asserted mid-tone SHALL silence buzzer immediately (asynchronously).
REQ-033 The first valid key after reset deassertion SHALL be treated as a fresh IDLE-to-PLAY start.

Structure
REQ-034 The frequency list, NUM_NOTES maximum and state encodings SHALL live in the shared package piano_pkg.
REQ-035 The half-period lookup, including shift and clamp, SHALL be the sub-module tone_table (combinational ROM, parameter CLK_HZ).
REQ-036 The state machine, counters and output registers SHALL reside in tone_gen.

Verification
REQ-037 Scenario: key=5, octave=0, key_on=1 held -> first buzzer rise 113636 clocks after latch, period 227272 clocks, active=1, note_q=5.
REQ-038 Scenario: key=5, octave=1 -> half=56818. Then switch octave to 0 mid-tone -> buzzer=0 and counter=0 on the next cycle, then half=113636.
REQ-039 Scenario: RELEASE_CYC=1000, key=0 sounding, then key_on dropped -> toggling continues for 1000 clocks with half=191570, then buzzer=0 and active=0.
REQ-040 Scenario: same setup, key_on reasserted with key=0 at release cycle 500 -> PLAY with no phase glitch (toggle spacing unchanged).
REQ-041 Scenario: key=20 with key_on=1 from IDLE -> remains IDLE, buzzer=0, active=0. Sending key=20 during PLAY -> enters RELEASE.
REQ-042 Scenario: rst pulsed mid-tone while buzzer=1 -> buzzer=0 with no clock edge required, all outputs 0, and a clean restart afterwards.
